regspace_req_arbiter: RTL and testbench



---
 rtl/regspace_arb_pkg.sv | 16 +
 rtl/regspace_req_arbiter_rr.sv | 36 +++
 rtl/regspace_req_arbiter.sv | 179 +++++++++++++++++
 tb/tb_regspace_req_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regspace_arb_pkg.sv
// Shared types and defaults for the register-space request arbiter.
package regspace_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_ACK = 3'd2,
        WR_REQ = 3'd3,
        RSP    = 3'd4
    } arb_state_e;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int TO_DEFAULT = 255;

endpackage

// File: rtl/regspace_req_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above rr_ptr, wrapping.
module rr_arbiter_onehot #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/regspace_req_arbiter.sv
// Round-robin sharing of one register-space read/write interface among NUM_REQ
// masters, one transaction in flight, with a downstream wait timeout.
module regspace_req_arbiter
    import regspace_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TO_CYC  = TO_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    input  logic [NUM_REQ-1:0]        rsp_rdy,
    output logic [ADDR_W-1:0]         rreq_addr,
    output logic                      rreq_vld,
    input  logic                      rreq_rdy,
    input  logic [DATA_W-1:0]         rack_data,
    input  logic                      rack_vld,
    output logic                      rack_rdy,
    output logic [ADDR_W-1:0]         wreq_addr,
    output logic [DATA_W-1:0]         wreq_data,
    output logic                      wreq_vld,
    input  logic                      wreq_rdy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TO_CYC + 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, gnt_idx_q, ptr_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rsp_data_q;
    logic                rsp_err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any, to_hit, waiting;
    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    rr_arbiter_onehot #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_vld),
        .rr_ptr  (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    assign arb_any  = |req_vld;
    assign ptr_next = (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + IDX_W'(1);
    assign waiting  = (state_q == RD_REQ) || (state_q == RD_ACK) || (state_q == WR_REQ);
    // Expiry is the last permitted wait cycle; a handshake in it still wins.
    assign to_hit   = (cnt_q == CNT_W'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_idx_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || !waiting) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gnt_idx_q <= arb_idx;
                        addr_q    <= addr_arr[arb_idx];
                        wdata_q   <= wdata_arr[arb_idx];
                        rr_ptr_q  <= ptr_next;
                    end
                end
                RD_REQ: begin
                    if (!rreq_rdy && to_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                RD_ACK: begin
                    if (rack_vld) begin
                        rsp_data_q <= rack_data;
                        rsp_err_q  <= 1'b0;
                    end else if (to_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (wreq_rdy || to_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= !wreq_rdy;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_any) state_d = req_write[arb_idx] ? WR_REQ : RD_REQ;
            end
            RD_REQ: begin
                if (rreq_rdy)    state_d = RD_ACK;
                else if (to_hit) state_d = RSP;
            end
            RD_ACK: begin
                if (rack_vld || to_hit) state_d = RSP;
            end
            WR_REQ: begin
                if (wreq_rdy || to_hit) state_d = RSP;
            end
            RSP: begin
                if (rsp_rdy[gnt_idx_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_rdy   = '0;
        rsp_vld   = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        rreq_vld  = 1'b0;
        rreq_addr = '0;
        rack_rdy  = 1'b0;
        wreq_vld  = 1'b0;
        wreq_addr = '0;
        wreq_data = '0;
        case (state_q)
            IDLE: begin
                if (!rst) req_rdy = arb_gnt;
            end
            RD_REQ: begin
                rreq_vld  = 1'b1;
                rreq_addr = addr_q;
            end
            RD_ACK: rack_rdy = 1'b1;
            WR_REQ: begin
                wreq_vld  = 1'b1;
                wreq_addr = addr_q;
                wreq_data = wdata_q;
            end
            RSP: begin
                rsp_vld  = NUM_REQ'(1) << gnt_idx_q;
                rsp_data = rsp_data_q;
                rsp_err  = rsp_err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regspace_req_arbiter.sv
// Bench for regspace_req_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_regspace_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TO_CYC  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic [NUM_REQ-1:0]        req_vld, req_write, req_rdy, rsp_vld, rsp_rdy;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]         rsp_data, rack_data, wreq_data;
    logic                      rsp_err, rreq_vld, rreq_rdy, rack_vld, rack_rdy, wreq_vld, wreq_rdy;
    logic [ADDR_W-1:0]         rreq_addr, wreq_addr;

    regspace_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_rdy(rsp_rdy), .rreq_addr(rreq_addr), .rreq_vld(rreq_vld), .rreq_rdy(rreq_rdy),
        .rack_data(rack_data), .rack_vld(rack_vld), .rack_rdy(rack_rdy),
        .wreq_addr(wreq_addr), .wreq_data(wreq_data), .wreq_vld(wreq_vld), .wreq_rdy(wreq_rdy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the one in-flight transaction and its progress.
    int                m_ptr, m_idx, m_wait;
    bit                m_busy, m_write, m_sent, m_done, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_data;

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic compare_all();
        int p;
        logic [NUM_REQ-1:0] e_rdy, e_rsp;
        bit e_rreq, e_rack, e_wreq;
        p      = pick(req_vld, m_ptr);
        e_rdy  = (!m_busy && p >= 0) ? NUM_REQ'(1) << p : '0;
        e_rreq = m_busy && !m_write && !m_sent && !m_done;
        e_rack = m_busy && !m_write &&  m_sent && !m_done;
        e_wreq = m_busy &&  m_write && !m_done;
        e_rsp  = (m_busy && m_done) ? NUM_REQ'(1) << m_idx : '0;
        chk("req_rdy",  64'(req_rdy),  64'(e_rdy));
        chk("rreq_vld", 64'(rreq_vld), 64'(e_rreq));
        chk("rack_rdy", 64'(rack_rdy), 64'(e_rack));
        chk("wreq_vld", 64'(wreq_vld), 64'(e_wreq));
        chk("rsp_vld",  64'(rsp_vld),  64'(e_rsp));
        if (e_rreq) chk("rreq_addr", 64'(rreq_addr), 64'(m_addr));
        if (e_wreq) begin
            chk("wreq_addr", 64'(wreq_addr), 64'(m_addr));
            chk("wreq_data", 64'(wreq_data), 64'(m_wdata));
        end
        if (e_rsp != 0) begin
            chk("rsp_data", 64'(rsp_data), 64'(m_data));
            chk("rsp_err",  64'(rsp_err),  64'(m_err));
        end
    endtask

    task automatic model_update();
        bit hs;
        int p;
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            p = pick(req_vld, m_ptr);
            if (p >= 0) begin
                m_busy  = 1; m_idx = p; m_write = req_write[p];
                m_addr  = req_addr[p*ADDR_W +: ADDR_W];
                m_wdata = req_wdata[p*DATA_W +: DATA_W];
                m_sent  = 0; m_done = 0; m_wait = 0;
                m_ptr   = (p + 1) % NUM_REQ;
            end
        end else if (m_done) begin
            if (rsp_rdy[m_idx]) m_busy = 0;
        end else begin
            hs = m_write ? wreq_rdy : (!m_sent ? rreq_rdy : rack_vld);
            if (hs && !m_write && !m_sent) begin
                m_sent = 1; m_wait = 0;
            end else if (hs) begin
                m_done = 1; m_err = 0; m_data = m_write ? '0 : rack_data;
            end else begin
                m_wait++;
                if (m_wait == TO_CYC) begin
                    m_done = 1; m_err = 1; m_data = '0;
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_vld[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got_g[4];
        int ng, saw;
        rst = 1'b1; req_vld = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        rsp_rdy = '0; rreq_rdy = 1'b0; rack_vld = 1'b0; rack_data = '0; wreq_rdy = 1'b0;
        m_busy = 0; m_ptr = 0; m_idx = 0; m_wait = 0; m_write = 0; m_sent = 0;
        m_done = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_data = '0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_outs", 64'({req_rdy, rsp_vld, rsp_err, rsp_data, rreq_vld, rack_rdy, wreq_vld}), 64'(0));
        chk("reset_state", 64'(int'(dut.state_q)), 64'(0));
        chk("reset_ptr", 64'(dut.rr_ptr_q), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        // single read, zero-wait downstream
        set_req(0, 1'b0, 16'h0010, '0);
        rreq_rdy = 1'b1; rack_vld = 1'b1; rack_data = 32'hDEADBEEF;
        #1 chk("rd_accept", 64'(req_rdy), 64'(2'b01));
        tick(); req_vld = '0;
        chk("rd_rreq_n1", 64'({rreq_vld, rreq_addr}), 64'({1'b1, 16'h0010}));
        tick();
        chk("rd_rack_n2", 64'(rack_rdy), 64'(1));
        tick();
        chk("rd_rsp_n3", 64'({rsp_vld, rsp_err}), 64'({2'b01, 1'b0}));
        chk("rd_data", 64'(rsp_data), 64'(32'hDEADBEEF));
        rsp_rdy = 2'b01; tick();
        rsp_rdy = '0; rack_vld = 1'b0; rreq_rdy = 1'b0;
        chk("rd_rsp_gone", 64'(rsp_vld), 64'(0));

        // single write, wreq_rdy low 3 cycles, handshake on the expiry cycle
        set_req(1, 1'b1, 16'h0004, 32'h12345678);
        #1 chk("wr_accept", 64'(req_rdy), 64'(2'b10));
        tick(); req_vld = '0;
        for (int c = 0; c < 4; c++) begin
            chk("wr_hold", 64'({wreq_vld, wreq_addr, wreq_data}), {15'd0, 1'b1, 16'h0004, 32'h12345678});
            if (c == 3) wreq_rdy = 1'b1;
            tick();
        end
        wreq_rdy = 1'b0;
        chk("wr_rsp", 64'({rsp_vld, rsp_err}), 64'({2'b10, 1'b0}));
        chk("wr_rsp_data", 64'(rsp_data), 64'(0));
        rsp_rdy = 2'b10; tick(); rsp_rdy = '0;

        // round robin with both requesters continuously valid
        set_req(0, 1'b1, 16'h0100, 32'hA0);
        set_req(1, 1'b1, 16'h0101, 32'hA1);
        wreq_rdy = 1'b1; rsp_rdy = 2'b11; ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (req_rdy != '0) begin
                got_g[ng] = req_rdy[1] ? 1 : 0;
                ng++;
            end
            tick();
            if (ng == 4) req_vld = '0;
        end
        chk("rr_count", 64'(ng), 64'(4));
        for (int k = 0; k < 4; k++) chk("rr_order", 64'(got_g[k]), 64'(k % 2));
        chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(0));
        repeat (3) tick();
        wreq_rdy = 1'b0; rsp_rdy = '0;

        // read-data timeout, then a late rack_vld
        set_req(0, 1'b0, 16'h0200, '0);
        rreq_rdy = 1'b1;
        tick(); req_vld = '0;
        tick();
        for (int c = 0; c < TO_CYC; c++) begin
            chk("to_rack_rdy", 64'(rack_rdy), 64'(1));
            tick();
        end
        chk("to_rack_drop", 64'(rack_rdy), 64'(0));
        chk("to_rsp", 64'({rsp_vld, rsp_err}), 64'({2'b01, 1'b1}));
        chk("to_rsp_data", 64'(rsp_data), 64'(0));
        rack_vld = 1'b1; rack_data = 32'h5555AAAA;
        #1 chk("to_late_rack", 64'(rack_rdy), 64'(0));
        tick();
        chk("to_err_held", 64'({rsp_err, rsp_data}), 64'({1'b1, 32'h0}));
        rack_vld = 1'b0; rsp_rdy = 2'b01; tick(); rsp_rdy = '0; rreq_rdy = 1'b0;

        // response backpressure while requester 1 waits
        set_req(0, 1'b1, 16'h0300, 32'hBB);
        wreq_rdy = 1'b1;
        #1 chk("bp_accept0", 64'(req_rdy), 64'(2'b01));
        tick();
        req_vld[0] = 1'b0;
        set_req(1, 1'b0, 16'h0301, '0);
        rsp_rdy = 2'b10;
        tick();
        wreq_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rsp_hold", 64'(rsp_vld), 64'(2'b01));
            chk("bp_no_grant1", 64'(req_rdy[1]), 64'(0));
            tick();
        end
        rsp_rdy = 2'b01;
        tick();
        rsp_rdy = '0;
        #1 chk("bp_grant1", 64'(req_rdy), 64'(2'b10));

        // reset during RD_ACK abandons the read
        rreq_rdy = 1'b1;
        tick(); req_vld = '0;
        tick();
        chk("rst_in_ack", 64'(rack_rdy), 64'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_outs", 64'({req_rdy, rsp_vld, rsp_err, rsp_data, rreq_vld, rack_rdy, wreq_vld}), 64'(0));
        chk("rst_state", 64'(int'(dut.state_q)), 64'(0));
        chk("rst_ptr", 64'(dut.rr_ptr_q), 64'(0));
        rack_vld = 1'b1; rsp_rdy = 2'b11; saw = 0;
        repeat (6) begin
            tick();
            if (rsp_vld != '0) saw++;
        end
        chk("rst_no_rsp", 64'(saw), 64'(0));
        rack_vld = 1'b0; rreq_rdy = 1'b0; rsp_rdy = '0;

        // random traffic with occasional resets
        repeat (800) begin
            rst       = ($urandom_range(0, 79) == 0);
            req_vld   = rst ? '0 : NUM_REQ'($urandom);
            req_write = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
                req_wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            rreq_rdy  = ($urandom_range(0, 3) == 0);
            wreq_rdy  = ($urandom_range(0, 3) == 0);
            rack_vld  = ($urandom_range(0, 2) == 0);
            rack_data = DATA_W'($urandom);
            rsp_rdy   = NUM_REQ'($urandom);
            tick();
        end
        rst = 1'b0; req_vld = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
